result_display_ctrl: RTL and testbench

Consumes the classifier result and the controller status code, and drives a 4-digit multiplexed common-anode 7-segment display. It replaces the single combinational digit decode with a scanned, registered display:
- digit 0: latched result
- digit 1: status code in hex
- digits 3:2: two-digit inference counter

The block sits downstream of the BNN interface and FSM controller in the system top level.

---
 rtl/result_display_ctrl_if.sv | 20 ++
 rtl/result_display_ctrl.sv | 153 +++++++++++++++
 tb/tb_result_display_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/result_display_ctrl_if.sv
// rtl/result_display_ctrl_if.sv - result/status inputs and 7-segment outputs of result_display_ctrl
interface result_display_ctrl_if;
    logic       result_ready;
    logic [3:0] result_out;
    logic [3:0] status_code;
    logic       clear;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output result_ready, result_out, status_code, clear,
        input  seg, an, dp
    );

    modport slave (
        input  result_ready, result_out, status_code, clear,
        output seg, an, dp
    );
endinterface

// File: rtl/result_display_ctrl.sv
// rtl/result_display_ctrl.sv - scanned 4-digit 7-segment display of result, status and event count
// Optional digit-0 blink after a new result: define RESULT_DISPLAY_BLINK_EN.
module result_display_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_CYCLES = 10_000_000,
    parameter int BLINK_BIT    = 21
) (
    input logic                  clk,
    input logic                  rst_n,
    result_display_ctrl_if.slave bus
);
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

    if (REFRESH_DIV < 2 || BLINK_CYCLES < 0 || BLINK_BIT < 0 || BLINK_BIT > 31) begin : g_bad_cfg
        $error("result_display_ctrl: invalid parameter set");
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    logic          rr_q;
    logic [3:0]    res_q;
    logic          res_valid;
    logic [3:0]    cnt_ones;
    logic [3:0]    cnt_tens;
    logic [RW-1:0] ref_cnt;
    logic [1:0]    idx;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          new_evt;
    logic          latch_evt;
    logic          blink_off;

    assign new_evt   = bus.result_ready & ~rr_q;
    // clear beats a simultaneous event: nothing is latched and nothing is counted
    assign latch_evt = new_evt & ~bus.clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= 1'b0;
            res_q     <= 4'd0;
            res_valid <= 1'b0;
            cnt_ones  <= 4'd0;
            cnt_tens  <= 4'd0;
        end else begin
            rr_q <= bus.result_ready;
            if (bus.clear) begin
                res_valid <= 1'b0;
            end else if (latch_evt) begin
                res_q     <= bus.result_out;
                res_valid <= 1'b1;
                if (cnt_ones == 4'd9) begin
                    cnt_ones <= 4'd0;
                    cnt_tens <= (cnt_tens == 4'd9) ? 4'd0 : cnt_tens + 4'd1;
                end else begin
                    cnt_ones <= cnt_ones + 4'd1;
                end
            end
        end
    end

`ifdef RESULT_DISPLAY_BLINK_EN
    logic [31:0] blink_tmr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_tmr <= 32'd0;
        end else if (bus.clear) begin
            blink_tmr <= 32'd0;
        end else if (latch_evt) begin
            blink_tmr <= 32'(BLINK_CYCLES);
        end else if (blink_tmr != 32'd0) begin
            blink_tmr <= blink_tmr - 32'd1;
        end
    end

    assign blink_off = (blink_tmr != 32'd0) && blink_tmr[BLINK_BIT];
`else
    assign blink_off = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= '0;
            idx     <= 2'd0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    always_comb begin
        seg_d = GLYPH_BLANK;
        dp_d  = 1'b1;
        an_d  = ~(4'b0001 << idx);
        case (idx)
            2'd0: begin
                if (res_valid && !blink_off) begin
                    seg_d = (res_q > 4'd9) ? GLYPH_DASH : hex_glyph(res_q);
                    dp_d  = 1'b0;
                end
            end
            2'd1: seg_d = hex_glyph(bus.status_code);
            2'd2: seg_d = hex_glyph(cnt_ones);
            default: begin
                // leading-zero suppression on the tens digit
                if (cnt_tens != 4'd0) seg_d = hex_glyph(cnt_tens);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= GLYPH_BLANK;
            an_q  <= 4'hF;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.dp  = dp_q;
endmodule

// File: tb/tb_result_display_ctrl.sv
// tb/tb_result_display_ctrl.sv - randomized bench for result_display_ctrl against a digit-level model
module tb_result_display_ctrl;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_display_ctrl_if bus();

    result_display_ctrl #(.REFRESH_DIV(RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // model: cycles since reset release, latched result, and event count as a plain integer
    int k;
    int m_count;
    int m_res;
    bit m_valid;
    bit m_rr;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        k       = 0;
        m_count = 0;
        m_res   = 0;
        m_valid = 1'b0;
        m_rr    = 1'b0;
    endtask

    task automatic step();
        int         dig;
        logic [6:0] es;
        logic [3:0] ea;
        logic       ed;
        dig = (k / RD) % 4;
        ea  = ~(4'b0001 << dig);
        es  = 7'b1111111;
        ed  = 1'b1;
        case (dig)
            0: if (m_valid) begin
                   es = (m_res > 9) ? 7'b0111111 : glyph(m_res);
                   ed = 1'b0;
               end
            1: es = glyph(int'(bus.status_code));
            2: es = glyph(m_count % 10);
            default: if (m_count / 10 != 0) es = glyph(m_count / 10);
        endcase
        if (bus.clear) begin
            m_valid = 1'b0;
        end else if (bus.result_ready && !m_rr) begin
            m_res   = int'(bus.result_out);
            m_valid = 1'b1;
            m_count = (m_count + 1) % 100;
        end
        m_rr = bus.result_ready;
        @(posedge clk);
        #1;
        check($sformatf("seg k%0d d%0d", k, dig), 32'(bus.seg), 32'(es));
        check($sformatf("an k%0d", k), 32'(bus.an), 32'(ea));
        check($sformatf("dp k%0d d%0d", k, dig), 32'(bus.dp), 32'(ed));
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int v);
        bus.result_out   = 4'(v);
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
        check({tag, "_an"}, 32'(bus.an), 32'hF);
        check({tag, "_dp"}, 32'(bus.dp), 32'h1);
    endtask

    initial begin
        bus.result_ready = 1'b0;
        bus.result_out   = 4'd0;
        bus.status_code  = 4'd3;
        bus.clear        = 1'b0;
        model_reset();

        #22;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        run(16);

        // single-cycle pulse of result 7
        pulse(7);
        run(16);

        // held-high result_ready with result_out drifting 2 -> 5
        bus.result_out   = 4'd2;
        bus.result_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            bus.result_out = 4'(2 + (i + 1) * 3 / 20);
        end
        bus.result_ready = 1'b0;
        run(16);

        // clear coinciding with a rising edge
        bus.clear        = 1'b1;
        bus.result_out   = 4'd9;
        bus.result_ready = 1'b1;
        step();
        bus.clear        = 1'b0;
        bus.result_ready = 1'b0;
        run(16);

        // count up to 95, show a full frame, then wrap through 99 to 00
        for (int i = 0; i < 100 && m_count != 95; i++) pulse(i % 10);
        run(16);
        for (int i = 0; i < 5; i++) pulse(i);
        run(16);
        pulse(4);
        run(16);

        // hex letter on status and dash for an out-of-range result
        bus.status_code = 4'hB;
        pulse(12);
        run(16);

        for (int i = 0; i < 400; i++) begin
            bus.result_ready = ($urandom_range(0, 2) == 0) ? ~bus.result_ready : bus.result_ready;
            bus.result_out   = 4'($urandom_range(0, 15));
            bus.clear        = ($urandom_range(0, 15) == 0);
            bus.status_code  = 4'($urandom_range(0, 15));
            step();
        end
        bus.clear        = 1'b0;
        bus.result_ready = 1'b0;
        run(6);

        // asynchronous reset in the middle of a digit slot
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(posedge clk);
        #1;
        check_reset_outputs("arst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(16);
        pulse(5);
        run(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
